// File: rtl/dmem_pkg.sv
// dmem_pkg: funct3 codes, FSM encoding and index-width helper for dmem_responder
package dmem_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  function automatic int log2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/dmem_lane_merge.sv
// dmem_lane_merge: byte enables and lane-replicated store data for sb/sh/sw
module dmem_lane_merge
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o
);
  always_comb begin
    be_o    = funct3_i == F3_B ? 4'b0001 << addr_i : funct3_i == F3_H ? (addr_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata_o = funct3_i == F3_B ? {4{wdata_i[7:0]}} : funct3_i == F3_H ? {2{wdata_i[15:0]}} : wdata_i;
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding load/store responder with programmable wait states.
// Define DMEM_MISALIGN_ERR_EN to add rsp_err and reject misaligned/illegal accesses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int    DEPTH       = 1024,
  parameter int    WAIT_CYCLES = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata
`ifdef DMEM_MISALIGN_ERR_EN
  ,
  output logic        rsp_err
`endif
);
  localparam int IW = log2(DEPTH);
  localparam logic [3:0] WC = 4'(WAIT_CYCLES);
  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [31:0]   data_q;
  logic [31:0]   mem [DEPTH];
  logic [IW-1:0] idx;
  logic [3:0]    be;
  logic [31:0]   wlane;
  logic          accept, bad, unused_addr;
  assign idx         = req_addr[IW+1:2];
  assign unused_addr = ^req_addr[31:IW+2];
  assign req_ready   = state_q != WAIT;
  assign accept      = req_valid && req_ready;
  assign rsp_valid   = state_q == RESP;
  assign rsp_rdata   = rsp_valid ? data_q : 32'h0;
`ifdef DMEM_MISALIGN_ERR_EN
  logic err_q;
  assign bad = ((req_funct3 == F3_H || req_funct3 == F3_HU) && req_addr[0]) ||
               (req_funct3 == F3_W && req_addr[1:0] != 2'b00) ||
               req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11 || (req_we && req_funct3[2]);
  assign rsp_err = rsp_valid && err_q;
  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else if (accept) err_q <= bad;
  end
`else
  assign bad = 1'b0;
`endif
  dmem_lane_merge u_merge (
    .funct3_i(req_funct3),
    .addr_i  (req_addr[1:0]),
    .wdata_i (req_wdata),
    .be_o    (be),
    .wdata_o (wlane)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == WAIT) begin
      cnt_d   = cnt_q - 4'd1;
      state_d = cnt_q == 4'd1 ? RESP : WAIT;
    end else if (accept) begin
      cnt_d   = WC;
      state_d = WC == 4'd0 ? RESP : WAIT;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) data_q <= (req_we || bad) ? 32'h0 : mem[idx];
    end
  end
  // Stores commit at the accept edge so the next accepted load already sees them.
  always_ff @(posedge clk) begin
    if (accept && req_we && !bad && !reset)
      for (int b = 0; b < 4; b++) if (be[b]) mem[idx][8*b +: 8] <= wlane[8*b +: 8];
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized + directed check of two responders (0 and 3 wait states) against a byte-level model
module tb_dmem_responder;
  import dmem_pkg::*;
  localparam int W0 = 0;
  localparam int W1 = 3;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        reset;
  logic [1:0]  v, we, rdy, rv;
  logic [2:0]  f3 [2];
  logic [31:0] ad [2], wd [2], rd [2];
`ifdef DMEM_MISALIGN_ERR_EN
  logic [1:0]  er;
`endif
  int nvec = 0, nerr = 0;
  int cyc = 0;
  int pdue [2] = '{-1, -1};
  logic [31:0] pdat [2];
  logic perr [2];
  logic [7:0] mm [2][4096];
  int waited [2];
  bit chk = 0;

  dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(W0)) u0 (
    .clk(clk), .reset(reset), .req_valid(v[0]), .req_ready(rdy[0]), .req_we(we[0]),
    .req_funct3(f3[0]), .req_addr(ad[0]), .req_wdata(wd[0]), .rsp_valid(rv[0]), .rsp_rdata(rd[0])
`ifdef DMEM_MISALIGN_ERR_EN
    , .rsp_err(er[0])
`endif
  );
  dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(W1)) u3 (
    .clk(clk), .reset(reset), .req_valid(v[1]), .req_ready(rdy[1]), .req_we(we[1]),
    .req_funct3(f3[1]), .req_addr(ad[1]), .req_wdata(wd[1]), .rsp_valid(rv[1]), .rsp_rdata(rd[1])
`ifdef DMEM_MISALIGN_ERR_EN
    , .rsp_err(er[1])
`endif
  );

  task automatic cmp(string n, int i, logic [31:0] g, logic [31:0] x);
    nvec++;
    if (g !== x) begin
      nerr++;
      $display("FAIL %s dut%0d cycle %0d: got %h expected %h", n, i, cyc, g, x);
    end
  endtask

  function automatic int fsize(logic w, logic [2:0] f);
    if (f == 3'b000 || (!w && f == 3'b100)) return 1;
    if (f == 3'b001 || (!w && f == 3'b101)) return 2;
    return 4;
  endfunction

`ifdef DMEM_MISALIGN_ERR_EN
  function automatic bit ferr(logic w, logic [2:0] f, logic [31:0] a);
    return f == 3'b011 || f[2:1] == 2'b11 || (w && f[2]) || (a % fsize(w, f)) != 0;
  endfunction
`endif

  function automatic logic [31:0] word(int i, logic [31:0] a);
    int b = int'(a % 4096) & ~3;
    return {mm[i][b+3], mm[i][b+2], mm[i][b+1], mm[i][b]};
  endfunction

  task automatic take(int i);
    int s = fsize(we[i], f3[i]);
    int base = int'(ad[i] % 4096) / s * s;
    bit e = 0;
`ifdef DMEM_MISALIGN_ERR_EN
    e = ferr(we[i], f3[i], ad[i]);
`endif
    pdat[i] = (we[i] || e) ? 32'h0 : word(i, ad[i]);
    perr[i] = e;
    if (we[i] && !e)
      for (int k = 0; k < s; k++) mm[i][base+k] = wd[i][8*k +: 8];
    pdue[i] = cyc + (i == 0 ? W0 : W1) + 1;
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      if (reset) pdue[i] = -1;
      else if (v[i] && pdue[i] <= cyc) take(i);
    cyc++;
    if (reset) chk = 1;
  end

  always @(negedge clk) begin
    if (chk)
      for (int i = 0; i < 2; i++) begin
        cmp("req_ready", i, rdy[i], pdue[i] <= cyc);
        cmp("rsp_valid", i, rv[i], pdue[i] == cyc);
        cmp("rsp_rdata", i, rd[i], pdue[i] == cyc ? pdat[i] : 32'h0);
`ifdef DMEM_MISALIGN_ERR_EN
        cmp("rsp_err", i, er[i], pdue[i] == cyc && perr[i]);
`endif
      end
  end

  task automatic req(int i, logic w, logic [2:0] f, logic [31:0] a, logic [31:0] d);
    bit acc = 0;
    v[i] = 1'b1; we[i] = w; f3[i] = f; ad[i] = a; wd[i] = d;
    waited[i] = 0;
    while (!acc && waited[i] < 40) begin
      acc = rdy[i];
      @(negedge clk);
      if (!acc) waited[i]++;
    end
    if (!acc) begin
      nvec++; nerr++;
      $display("FAIL req_accept dut%0d: got no accept expected accept within 40 cycles", i);
    end
  endtask

  task automatic pin(int i, string n, logic [31:0] x, int lat);
    int k = 0;
    while (!rv[i] && k < 20) begin
      @(negedge clk);
      k++;
    end
    cmp({n, "_latency"}, i, k, lat);
    cmp(n, i, rd[i], x);
  endtask

  task automatic sweep(int i);
    for (int w = 0; w < 64; w++) req(i, 1'b1, F3_W, 32'(w * 4), $urandom());
    v[i] = 1'b0;
  endtask

  task automatic rnd(int i, int n);
    logic [31:0] r;
    for (int t = 0; t < n; t++) begin
      r = $urandom();
      req(i, r[0], r[3:1], {r[31:12], 4'h0, 8'($urandom_range(0, 255))}, $urandom());
      if ($urandom_range(0, 3) == 0) begin
        v[i] = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    v[i] = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no completion expected completion within 30000 cycles");
    $fatal(1);
  end

  initial begin
    int n;
    v = '0; we = '0;
    for (int i = 0; i < 2; i++) begin f3[i] = '0; ad[i] = '0; wd[i] = '0; end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    cmp("t1_ready", 0, rdy[0], 1);
    cmp("t1_valid", 0, rv[0], 0);
    cmp("t1_rdata", 0, rd[0], 0);
    fork sweep(0); sweep(1); join
    @(negedge clk);
    req(0, 1'b1, F3_W, 32'h10, 32'hDEADBEEF);
    req(0, 1'b0, F3_W, 32'h10, 32'h0);
    v[0] = 1'b0;
    pin(0, "t2_lw", 32'hDEADBEEF, 0);
    req(0, 1'b1, F3_W, 32'h20, 32'h11223344);
    req(0, 1'b1, F3_B, 32'h22, 32'h000000AA);
    req(0, 1'b0, F3_W, 32'h20, 32'h0);
    v[0] = 1'b0;
    pin(0, "t3_sb", 32'h11AA3344, 0);
    req(0, 1'b1, F3_H, 32'h20, 32'h0000BEEF);
    req(0, 1'b0, F3_W, 32'h20, 32'h0);
    v[0] = 1'b0;
    pin(0, "t3_sh", 32'h11AABEEF, 0);
    req(1, 1'b1, F3_W, 32'h40, 32'hCAFEF00D);
    req(1, 1'b0, F3_W, 32'h40, 32'h0);
    cmp("t4_held_wait", 1, waited[1], 3);
    v[1] = 1'b0;
    pin(1, "t4_lw", 32'hCAFEF00D, 3);
    req(0, 1'b1, F3_W, 32'h1000, 32'h5);
    req(0, 1'b0, F3_W, 32'h0, 32'h0);
    v[0] = 1'b0;
    pin(0, "t5_wrap", 32'h5, 0);
    req(1, 1'b1, F3_W, 32'h80, 32'h77);
    v[1] = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    repeat (6) begin
      if (rv[1]) n++;
      @(negedge clk);
    end
    cmp("t5_dropped_rsp", 1, n, 0);
    req(1, 1'b0, F3_W, 32'h80, 32'h0);
    v[1] = 1'b0;
    pin(1, "t5_store_kept", 32'h77, 3);
`ifdef DMEM_MISALIGN_ERR_EN
    req(0, 1'b1, F3_W, 32'h13, 32'h12345678);
    v[0] = 1'b0;
    pin(0, "t6_sw_mis_rdata", 32'h0, 0);
    cmp("t6_sw_mis_err", 0, er[0], 1);
    req(0, 1'b0, F3_W, 32'h10, 32'h0);
    v[0] = 1'b0;
    pin(0, "t6_word_kept", 32'hDEADBEEF, 0);
    req(0, 1'b0, F3_H, 32'h21, 32'h0);
    v[0] = 1'b0;
    pin(0, "t6_lh_mis_rdata", 32'h0, 0);
    cmp("t6_lh_mis_err", 0, er[0], 1);
`endif
    fork rnd(0, 300); rnd(1, 150); join
    repeat (8) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
